// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the queued fetch entry type for the
// instruction fetch stage.
//   ADDR_W / INSTR_W : address and instruction widths (32)
//   PC_STEP          : sequential PC increment (4 bytes)
//   NOP              : canonical RISC-V nop encoding (addi x0, x0, 0)
//   fetch_entry_t    : {pc, instr} pair handed to decode
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with a single-cycle flush.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries (power of 2, >= 1)
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-low
//   flush      in   drop all entries (wins over push/pop in the same cycle)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH  data to write
//   pop        in   remove the head entry (ignored when empty)
//   pop_data   out  WIDTH  head entry (valid while !empty)
//   empty      out  no entries held
//   count      out  number of entries held
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is accepted when the head leaves in the same
    // cycle, so the count stays put instead of the write being lost.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage paired with an external PC register.
// Issues in-order reads over req/gnt/rvalid, queues {pc, instr} pairs and
// hands them to decode over valid/ready. A redirect flushes the stage and
// discards every response still in flight.
// Optional build macro: FETCH_MISALIGN_CHK_EN adds the if_misalign output.
// Parameters:
//   DEPTH            output queue entries (power of 2, >= 2)
//   MAX_OUTSTANDING  max granted-but-unanswered requests (power of 2, >= 1)
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-low
//   pc           in   32  current PC from the PC register
//   pc_next      out  32  next PC fed back to the PC register
//   redirect     in   branch/jump taken; flush the stage
//   redirect_pc  in   32  redirect target
//   imem_req     out  read request
//   imem_addr    out  32  read address (= pc)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   read data valid (in-order responses)
//   imem_rdata   in   32  read data
//   if_valid     out  fetched instruction available
//   if_ready     in   decode accepts
//   if_misalign  out  head pc not word aligned (FETCH_MISALIGN_CHK_EN only)
//   if_instr     out  32  instruction
//   if_pc        out  32  PC of if_instr
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic               if_misalign,
`endif
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(DEPTH + 1);
    localparam int SW = ((OW > QW) ? OW : QW) + 1;

    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic              addr_empty;
    logic [ADDR_W-1:0] rsp_addr;
    logic [QW-1:0]     out_count;
    logic              out_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic [SW-1:0]     in_flight;
    logic              pop_out;
    logic              accepted;
    logic              rsp;
    logic              keep_rsp;

    // Credit check: every granted request must find a free output slot when
    // its data returns. A slot being handed to decode this cycle counts as
    // free, which is what lets a 1-cycle memory stream one instruction per
    // cycle with only two entries.
    always_comb begin
        pop_out   = !out_empty && if_ready;
        in_flight = SW'(outstanding) + SW'(out_count) - SW'(pop_out);
        imem_req  = rst && !redirect
                    && (outstanding < OW'(MAX_OUTSTANDING))
                    && (in_flight < SW'(DEPTH));
        accepted  = imem_req && imem_gnt;
        // An rvalid with nothing outstanding is a protocol error and is ignored.
        rsp       = rst && imem_rvalid && !addr_empty;
        keep_rsp  = rsp && !redirect && (drop_cnt == '0);
    end

    always_comb begin
        if (!rst) begin
            pc_next = '0;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (accepted) begin
            pc_next = pc + PC_STEP;
        end else begin
            pc_next = pc;
        end
    end

    assign imem_addr = pc;

    // Address queue: the PC of each request in flight, so the returning data
    // can be paired with it. Its occupancy is the outstanding count. It is
    // never flushed on redirect because the stale responses still arrive.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accepted),
        .push_data (pc),
        .pop       (rsp),
        .pop_data  (rsp_addr),
        .empty     (addr_empty),
        .count     (outstanding)
    );

    // On redirect every request still in flight belongs to the old path.
    // The response arriving in the redirect cycle itself is already excluded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= outstanding - OW'(rsp);
        end else if (rsp && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_comb begin
        push_entry.pc    = rsp_addr;
        push_entry.instr = imem_rdata;
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (keep_rsp),
        .push_data (push_entry),
        .pop       (pop_out),
        .pop_data  (head_entry),
        .empty     (out_empty),
        .count     (out_count)
    );

    // Outputs read as zero while empty so nothing stale leaks to decode.
    always_comb begin
        if_valid = !out_empty;
        if_pc    = if_valid ? head_entry.pc    : '0;
        if_instr = if_valid ? head_entry.instr : '0;
    end

`ifdef FETCH_MISALIGN_CHK_EN
    assign if_misalign = if_valid && (head_entry.pc[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (rst && imem_rvalid) begin
            assert (!addr_empty);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// The bench plays the PC register (pc follows pc_next each cycle) and an
// in-order memory with random grant/response timing. The reference model only
// knows the program order: deliveries run pc, pc+4, ... from the last redirect
// target (or 0 after reset), and each instruction is a fixed hash of its address.
// Build with FETCH_MISALIGN_CHK_EN to also check if_misalign.
module tb_instr_fetch;

    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    instr_fetch #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
`ifdef FETCH_MISALIGN_CHK_EN
        .if_misalign (if_misalign),
`endif
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    int          gnt_pct;
    int          rv_pct;
    int          rdy_pct;
    logic        redir_now;
    logic [31:0] redir_tgt;

    logic [31:0] exp_pc;
    logic [31:0] pend[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_deliv   = 0;
    int          n_grants  = 0;
    int          n_valid   = 0;
    int          n_rsp     = 0;
    int          wrap_hits = 0;
    logic        prev_redirect = 1'b0;
    logic        prev_stall    = 1'b0;
    logic [31:0] prev_if_pc    = '0;
    logic [31:0] prev_if_instr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[15:8], ~a[23:16], a[31:24]} ^ 32'h9E37_79B9;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // One clock cycle: drive inputs just after posedge, observe at negedge,
    // then advance the PC register and the memory model at the next posedge.
    task automatic applyStimulus();
        logic        granted;
        logic        rsp_seen;
        logic        rst_seen;
        logic [31:0] grant_addr;
        logic [31:0] nxt_pc;
        imem_gnt    = int'($urandom_range(99)) < gnt_pct;
        imem_rvalid = (pend.size() > 0) && (int'($urandom_range(99)) < rv_pct);
        imem_rdata  = imem_rvalid ? mem_word(pend[0]) : $urandom;
        if_ready    = int'($urandom_range(99)) < rdy_pct;
        redirect    = redir_now;
        redirect_pc = redir_tgt;
        redir_now   = 1'b0;

        @(negedge clk);
        rst_seen   = rst;
        granted    = imem_req && imem_gnt;
        grant_addr = imem_addr;
        rsp_seen   = imem_rvalid;
        if (rst) begin
            if (imem_req) checkOutput("imem_addr", imem_addr, pc);
            if (redirect) checkOutput("req_in_redirect", imem_req, 1'b0);
            if (prev_redirect) begin
                checkOutput("valid_after_redirect", if_valid, 1'b0);
            end else if (prev_stall) begin
                checkOutput("head_stable_valid", if_valid, 1'b1);
                checkOutput("head_stable_pc", if_pc, prev_if_pc);
                checkOutput("head_stable_instr", if_instr, prev_if_instr);
            end
            if (if_valid && if_ready) begin
                checkOutput("if_pc", if_pc, exp_pc);
                checkOutput("if_instr", if_instr, mem_word(exp_pc));
`ifdef FETCH_MISALIGN_CHK_EN
                checkOutput("if_misalign", if_misalign, exp_pc[1:0] != 2'b00);
`endif
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (if_valid) n_valid++;
            if (rsp_seen) n_rsp++;
            if (granted) n_grants++;
            if (granted && pc == 32'hFFFF_FFFC) begin
                wrap_hits++;
                checkOutput("wrap_pc_next", pc_next, 32'h0000_0000);
            end
            if (redirect) exp_pc = redirect_pc;
            prev_redirect = redirect;
            prev_stall    = if_valid && !if_ready && !redirect;
            prev_if_pc    = if_pc;
            prev_if_instr = if_instr;
        end else begin
            exp_pc        = '0;
            prev_redirect = 1'b0;
            prev_stall    = 1'b0;
        end
        nxt_pc = pc_next;

        @(posedge clk);
        #1;
        if (!rst_seen) begin
            pend.delete();
        end else begin
            if (rsp_seen) void'(pend.pop_front());
            if (granted) pend.push_back(grant_addr);
        end
        pc = nxt_pc;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic setKnobs(input int g, input int r, input int d);
        gnt_pct = g;
        rv_pct  = r;
        rdy_pct = d;
    endtask

    initial begin
        int v0;
        int d0;
        int g0;
        int r0;
        int r_before;
        int t;
        rst = 1'b0; pc = '0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        redir_now = 1'b0; redir_tgt = '0; exp_pc = '0;
        setKnobs(100, 100, 100);
        @(posedge clk);
        #1;

        // Reset held for 3 cycles with grants offered
        runCycles(3);
        checkOutput("reset_if_valid", if_valid, 1'b0);
        checkOutput("reset_imem_req", imem_req, 1'b0);
        checkOutput("reset_pc_next", pc_next, 32'h0);
        checkOutput("reset_if_pc", if_pc, 32'h0);
        checkOutput("reset_if_instr", if_instr, 32'h0);
        rst = 1'b1;

        // Streaming with a 1-cycle memory: one delivery every cycle
        $display("[TB] streaming");
        runCycles(3);
        v0 = n_valid;
        d0 = n_deliv;
        runCycles(16);
        checkOutput("stream_valid_cycles", n_valid - v0, 16);
        checkOutput("stream_deliveries", n_deliv - d0, 16);

        // Backpressure: drain, then stall decode with grants always available
        $display("[TB] backpressure");
        setKnobs(0, 100, 100);
        runCycles(6);
        setKnobs(100, 100, 0);
        g0 = n_grants;
        runCycles(12);
        checkOutput("stall_grants", n_grants - g0, DEPTH);
        checkOutput("stall_imem_req", imem_req, 1'b0);
        checkOutput("stall_pc_hold", pc_next, pc);
        checkOutput("stall_if_valid", if_valid, 1'b1);
        setKnobs(100, 100, 100);
        d0 = n_deliv;
        runCycles(8);
        checkOutput("release_deliveries", (n_deliv - d0) >= DEPTH, 1'b1);

        // Redirect with two requests outstanding and no responses yet
        $display("[TB] redirect");
        setKnobs(100, 0, 100);
        runCycles(4);
        checkOutput("outstanding_before_redirect", pend.size(), MAX_OUT);
        redir_now = 1'b1;
        redir_tgt = 32'h0000_0100;
        applyStimulus();
        rv_pct = 100;
        r0 = n_rsp;
        d0 = n_deliv;
        r_before = n_rsp;
        t = 0;
        while (n_deliv == d0 && t < 20) begin
            r_before = n_rsp;
            applyStimulus();
            t++;
        end
        checkOutput("redirect_delivery_seen", n_deliv > d0, 1'b1);
        checkOutput("redirect_rvalids_before_data", r_before - r0, 3);
        runCycles(6);

        // 32-bit wrap of the sequential PC
        $display("[TB] wrap");
        redir_now = 1'b1;
        redir_tgt = 32'hFFFF_FFF0;
        runCycles(12);
        checkOutput("wrap_grants_at_top", wrap_hits, 1);

`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned redirect target is delivered and flagged
        $display("[TB] misalign");
        redir_now = 1'b1;
        redir_tgt = 32'h0000_0102;
        d0 = n_deliv;
        runCycles(8);
        checkOutput("misalign_deliveries", (n_deliv - d0) > 0, 1'b1);
        redir_now = 1'b1;
        redir_tgt = 32'h0000_0200;
        runCycles(4);
`endif

        // Random traffic with occasional redirects and one mid-run reset
        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            setKnobs(60, 60, 70);
            if (int'($urandom_range(99)) < 4) begin
                redir_now = 1'b1;
                redir_tgt = $urandom & 32'hFFFF_FFFC;
            end
            if (i == 200) begin
                redir_now = 1'b0;
                rst = 1'b0;
                runCycles(2);
                checkOutput("midreset_if_valid", if_valid, 1'b0);
                checkOutput("midreset_imem_req", imem_req, 1'b0);
                checkOutput("midreset_pc_next", pc_next, 32'h0);
                rst = 1'b1;
            end
            applyStimulus();
        end
        checkOutput("total_deliveries", n_deliv >= 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
